// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared combinational
// 8-bit sign-magnitude adder. Each transaction walks IDLE -> CALC -> RESP:
// a requester is granted in IDLE, its operands are presented to the adder
// during CALC, the normalized sum is captured, and it is held in RESP until
// the consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. On the request side, req_ready is
// combinational and one-hot, asserted only in IDLE for the round-robin winner.
// On the response side, rsp_valid/rsp_id/rsp_sum stay stable until
// rsp_ready is seen high.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = CALC, 2 = RESP.
module sm_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [8:0]           add_sum,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [8:0]           rsp_sum,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   pos;
  logic [IDW-1:0] cand;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) begin
        pos = pos - (IDW+1)'(NREQ);
      end
      cand = pos[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // One-hot grant, only while idle; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst) begin
      req_ready[win] = 1'b1;
    end
  end

  // Transaction sequencer; add_a/add_b double as the latched operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      add_a     <= 8'h00;
      add_b     <= 8'h00;
      rsp_sum   <= 9'h000;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            add_a <= req_a[{win, 3'b000} +: 8];
            add_b <= req_b[{win, 3'b000} +: 8];
            id    <= win;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // A zero magnitude is always stored as +0, whatever sign the adder gave.
          if (add_sum[7:0] == 8'h00) begin
            rsp_sum <= 9'h000;
          end else begin
            rsp_sum <= add_sum;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            add_a     <= 8'h00;
            add_b     <= 8'h00;
            // Pointer moves past the served requester only once its result is taken.
            if (id == IDW'(NREQ-1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= id + IDW'(1);
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_id    = id;
  assign dbg_state = state;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Bench for sm_add_arbiter: models the external sign-magnitude adder and
// the requesters, and predicts grants/responses from the arbitration rules
// with integer arithmetic and a queue of expected {id, sum} results.
module tb_sm_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_a;
  logic [8*NREQ-1:0]    req_b;
  logic [NREQ-1:0]      req_ready;
  logic [7:0]           add_a;
  logic [7:0]           add_b;
  logic [8:0]           add_sum;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [8:0]           rsp_sum;
  logic                 rsp_ready;
  logic                 busy;
  logic [1:0]           dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [IDW+8:0] exp_q[$];
  int             grant_log[$];
  int             m_phase;   // 0 idle, 1 computing, 2 response pending
  int             m_ptr;
  int             m_id;
  logic [7:0]     m_a;
  logic [7:0]     m_b;
  bit             refill;

  sm_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // External shared adder. Equal magnitudes with opposite signs take B's
  // sign, so it can emit -0 and the block's normalization is exercised.
  function automatic logic [8:0] adder_model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ma, mb;
    ma = {1'b0, a[6:0]};
    mb = {1'b0, b[6:0]};
    if (a[7] == b[7])  return {a[7], ma + mb};
    else if (ma > mb)  return {a[7], ma - mb};
    else               return {b[7], mb - ma};
  endfunction

  always_comb add_sum = adder_model(add_a, add_b);

  // Expected sum from signed integer arithmetic; zero is always +0.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    int va, vb, s;
    va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    s  = va + vb;
    if (s < 0) return {1'b1, 8'(-s)};
    else       return {1'b0, 8'(s)};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic raise(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_a     = 8'h00;
    m_b     = 8'h00;
    exp_q.delete();
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic [IDW+8:0]  head;
    int              w;
    bit              fire;
    #1;
    exp_rdy = '0;
    w       = -1;
    if (m_phase == 0) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    chk("add_a", 32'(add_a), 32'((m_phase != 0) ? m_a : 8'h00));
    chk("add_b", 32'(add_b), 32'((m_phase != 0) ? m_b : 8'h00));
    if (m_phase == 2 && exp_q.size() > 0) begin
      head = exp_q[0];
      chk("rsp_id", 32'(rsp_id), 32'(head[IDW+8:9]));
      chk("rsp_sum", 32'(rsp_sum), 32'(head[8:0]));
    end
    fire = (m_phase == 2) && rsp_ready;
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_phase = 1;
      m_id    = w;
      m_a     = req_a[w*8 +: 8];
      m_b     = req_b[w*8 +: 8];
      exp_q.push_back({IDW'(w), ref_sum(m_a, m_b)});
      grant_log.push_back(w);
      req_valid[w] = 1'b0;
      if (refill) raise(w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (fire) begin
      m_phase = 0;
      m_ptr   = (m_id + 1) % NREQ;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while (n < limit && !(m_phase == 0 && req_valid == '0)) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(m_phase == 0 && req_valid == '0), 32'd1);
  endtask

  task automatic directed(input string tag, input int idx, input logic [7:0] a,
                          input logic [7:0] b, input logic [8:0] exp_sum);
    logic [NREQ-1:0] one;
    one      = '0;
    one[idx] = 1'b1;
    rsp_ready = 1'b1;
    raise(idx, a, b);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(one));
    tick();
    tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
    run_until_idle(10);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    refill    = 1'b0;
    model_reset();

    // reset state, with requests pending to show grants are suppressed
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    req_valid = '0;
    rst       = 1'b0;

    // directed transactions
    directed("single", 1, 8'h05, 8'h83, 9'h002);
    directed("neg_big", 0, 8'hE4, 8'hE4, 9'h1C8);
    directed("neg_zero", 2, 8'h80, 8'h80, 9'h000);
    directed("cancel_zero", 3, 8'h05, 8'h85, 9'h000);

    // asynchronous reset while a response is pending
    rsp_ready = 1'b0;
    raise(2, 8'h11, 8'h22);
    tick();
    tick();
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid[0] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_sum", 32'(rsp_sum), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("arst_state_idle", 32'(dbg_state), 32'd0);
    rsp_ready = 1'b1;

    // round robin with every requester continuously asking
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) raise(i, 8'(8'h10 + i), 8'(8'h81 + i));
    refill = 1'b1;
    for (int n = 0; n < 40 && grant_log.size() < 5; n++) tick();
    refill = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", 32'((grant_log.size() > k) ? grant_log[k] : -1), 32'(k % NREQ));
    end
    run_until_idle(60);

    // backpressure: response held for 10 cycles while another request waits
    rsp_ready = 1'b0;
    raise(1, 8'h2A, 8'h8F);
    tick();
    raise(3, 8'h01, 8'h01);
    tick();
    repeat (10) tick();
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_id", 32'(rsp_id), 32'd1);
    chk("bp_sum", 32'(rsp_sum), 32'(9'h01B));
    chk("bp_no_grant", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'(4'b1000));
    run_until_idle(10);

    // randomized traffic with withdrawals and random backpressure
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 3) begin
          raise(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    run_until_idle(20);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sm_add_arbiter.md
Name: sm_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 8-bit sign-magnitude adder (9-bit sign-magnitude result) among NREQ requesters.
- Each requester offers an operand pair over a valid/ready handshake. The block drives the winner's operands into the shared adder, registers the result, and returns it tagged with the requester index.
- Sits between the client units and the single adder instance; the adder itself stays outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  8*NREQ  operand A per requester, slice i = bits [8i+7:8i]; bit 7 sign, bits 6:0 magnitude.
- req_b  input  8*NREQ  operand B per requester, same packing as req_a.
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- add_a  output  8  operand A to shared adder.
- add_b  output  8  operand B to shared adder.
- add_sum  input  9  shared adder result; bit 8 sign, bits 7:0 magnitude; combinational from add_a/add_b.
- rsp_valid  output  1  result valid.
- rsp_id  output  IDW  index of requester that owns the result.
- rsp_sum  output  9  registered, normalized sum.
- rsp_ready  input  1  consumer accepts result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, rr_ptr=0; all op/id/result registers cleared.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, add_a=add_b=0, busy=0.
  - An in-flight transaction is dropped silently.
- State machine, IDLE -> CALC -> RESP -> IDLE:
  - IDLE:
    - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
    - req_ready[winner]=1, combinational, only in IDLE and only if some req_valid is high.
    - On the clock edge with a winner: latch op_a, op_b and id=winner; go to CALC.
    - No valid request: stay in IDLE with req_ready=0.
  - CALC (exactly 1 cycle):
    - add_a=op_a, add_b=op_b.
    - At the edge, capture add_sum into the result register; go to RESP.
  - RESP:
    - rsp_valid=1; rsp_id and rsp_sum are held stable until accepted.
    - When rsp_ready=1 at the edge: rsp_valid drops, rr_ptr = (id+1) mod NREQ, go to IDLE.
    - Backpressure is unbounded.
- add_a/add_b equal op_a/op_b in CALC and RESP. They are 0 in IDLE.
- Normalization: if captured add_sum[7:0]==0, store rsp_sum=9'h000, forcing +0. Otherwise store add_sum unchanged.
- Latency: grant edge -> rsp_valid high 2 edges later. Peak throughput is 1 result per 3 cycles.
- Requesters must hold req_valid/req_a/req_b stable until granted. Deasserting req_valid before the grant withdraws the request legally; no grant is issued to a withdrawn request.
- Simultaneous requests: exactly one grant per IDLE visit; losers keep waiting.
- Fairness: each requester waits at most NREQ-1 foreign transactions.
- rr_ptr advances only on response acceptance, never on grant.
- req_valid bits at indices >= NREQ do not exist; rr_ptr never exceeds NREQ-1.

Test Plan:
- Reset check: assert rst mid-RESP with rsp_valid=1 -> rsp_valid, req_ready, busy go 0 immediately without a clock edge. After release, the state is IDLE.
- Single request: req 1 sends a=8'h05 (+5), b=8'h83 (-3), rsp_ready=1 -> req_ready=4'b0010 in the grant cycle; 2 edges later rsp_valid=1, rsp_id=1, rsp_sum=9'h002.
- Negative overflow magnitude: req 0 sends a=8'hE4 (-100), b=8'hE4 (-100) -> rsp_sum=9'h1C8 (-200), rsp_id=0.
- Zero normalization: a=8'h80 (-0), b=8'h80 -> rsp_sum=9'h000. Separately, a=8'h05, b=8'h85 -> rsp_sum=9'h000.
- Round-robin fairness: all four req_valid held high with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0. Each response carries the matching rsp_id and sum.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id, rsp_sum stay stable and req_ready stays 0. Raising rsp_ready gives one acceptance, then IDLE.
